rsa_job_ctrl: RTL
=================

RSA_JOB_CTRL -- requirements
Module: rsa_job_ctrl

Interface
REQ-001 Parameter: POLL_GAP, 16, idle cycles between flag polls (0 = back-to-back).
REQ-002 Parameter: TIMEOUT_CYC, 1048576, per-job watchdog limit in clk cycles (macro-gated).
REQ-003 clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  host requests a batch; cmd_count  in  16  jobs in batch.
REQ-005 cmd_ready  out  1  batch accepted when cmd_valid & cmd_ready.
REQ-006 abort  in  1  single-cycle request to stop the batch.
REQ-007 busy  out  1  batch in progress; done  out  1  one-cycle end-of-batch pulse.
REQ-008 error  out  1  sticky: batch ended by abort or timeout; jobs_done  out  16  completed jobs in current/last batch.
REQ-009 avm_address  out  1, avm_read  out  1, avm_write  out  1, avm_writedata  out  8: Avalon-MM master to the RSA flag slave.
REQ-010 avm_readdata  in  8, avm_waitrequest  in  1: zero-latency read data (no readdatavalid).

Function
REQ-011 States: IDLE, SET, GAP, POLL, CLR, DONE; cmd_ready=1 only in IDLE.
REQ-012 IDLE, accept, cmd_count=0 -> DONE next cycle, no bus traffic; cmd_count>0 -> SET; jobs_done and error cleared on accept.
REQ-013 SET: avm_write=1, avm_address=0, avm_writedata=8'h01, held stable until cycle with avm_waitrequest=0, then GAP (or POLL when POLL_GAP=0).
REQ-014 GAP: counter counts POLL_GAP cycles, then POLL.
REQ-015 POLL: avm_read=1, avm_address=0 held until avm_waitrequest=0; avm_readdata[0] sampled that cycle.
REQ-016 Sampled bit 1 -> GAP; bit 0 -> jobs_done+1; new jobs_done==cmd_count (latched) -> DONE, else SET next cycle.
REQ-017 DONE: done=1 exactly one cycle, busy falls same edge, return to IDLE.
REQ-018 avm_read and avm_write never both 1; at most one outstanding transaction; all bus outputs registered.
REQ-019 abort outside IDLE: latched; current bus transaction completes first (no command dropped while waitrequest=1); then CLR.
REQ-020 CLR: write 8'h00 to address 0 with same handshake as SET, then DONE with error=1.
REQ-021 abort in IDLE or DONE ignored; abort coinciding with final job completion -> completion wins, no CLR, error=0.
REQ-022 jobs_done 16-bit, no wrap possible (bounded by cmd_count); busy=1 in all states except IDLE.

Reset
REQ-023 Reset at any time: state IDLE, avm_read=0, avm_write=0, avm_writedata=0, avm_address=0, busy=0, done=0, error=0, jobs_done=0, counters 0, abort latch cleared.
REQ-024 Reset mid-transaction abandons it; no CLR write is issued.

Configuration
REQ-025 Macro RSA_JOB_TIMEOUT_EN defined: watchdog counts cycles from SET write acceptance; reaching TIMEOUT_CYC while in GAP/POLL acts as abort (REQ-019/020).
REQ-026 Watchdog restarts on every SET acceptance; disabled in IDLE/CLR/DONE.
REQ-027 Macro undefined: no watchdog logic; TIMEOUT_CYC ignored; batches wait indefinitely.

Structure
REQ-028 Shared package rsa_ctrl_pkg: state enum, FLAG_ADDR=1'b0, FLAG_SET=8'h01, FLAG_CLR=8'h00.
REQ-029 Watchdog is sub-module rsa_job_wdog (start, clear, expired), instantiated only under RSA_JOB_TIMEOUT_EN.

Verification
REQ-030 cmd_count=3, slave clears flag after 40 cycles each job, waitrequest=0 -> three 8'h01 writes, jobs_done 1,2,3, one done pulse, error=0.
REQ-031 cmd_count=0 -> done one cycle after accept, zero avm_read/avm_write cycles, jobs_done=0.
REQ-032 waitrequest held 1 for 5 cycles during SET and POLL -> address/data/strobe stable all 6 cycles, single acceptance each.
REQ-033 abort during POLL with waitrequest=1 -> read completes, one 8'h00 write, done pulse, error=1, jobs_done unchanged.
REQ-034 RSA_JOB_TIMEOUT_EN, TIMEOUT_CYC=100, flag never clears -> CLR write 8'h00 within 100+POLL_GAP+2 cycles of SET acceptance, error=1.
REQ-035 reset asserted mid-SET with waitrequest=1 -> next cycle all outputs at reset values, no further bus activity.

Source files
------------

// File: rtl/rsa_ctrl_pkg.sv
// Shared definitions for the RSA job controller: state encoding and the
// flag register address/values written to the RSA flag slave.
package rsa_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SET  = 3'd1,
        S_GAP  = 3'd2,
        S_POLL = 3'd3,
        S_CLR  = 3'd4,
        S_DONE = 3'd5
    } state_e;

    localparam logic       FLAG_ADDR = 1'b0;
    localparam logic [7:0] FLAG_SET  = 8'h01;
    localparam logic [7:0] FLAG_CLR  = 8'h00;

    // True in the states where the watchdog is allowed to run.
    function automatic logic wdog_active(input state_e s);
        logic act;
        case (s)
            S_SET, S_GAP, S_POLL: act = 1'b1;
            S_IDLE, S_CLR, S_DONE: act = 1'b0;
            default:              act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/rsa_job_ctrl_if.sv
// Avalon-MM link between the job controller (master) and the RSA flag
// slave. Read data is zero-latency: valid in the cycle waitrequest is low.
interface rsa_job_ctrl_if;
    logic       avm_address;
    logic       avm_read;
    logic       avm_write;
    logic [7:0] avm_writedata;
    logic [7:0] avm_readdata;
    logic       avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/rsa_job_wdog.sv
// Per-job watchdog for the RSA job controller. Only compiled when
// RSA_JOB_TIMEOUT_EN is defined. Counts clk cycles from 'start' and
// raises 'expired' once TIMEOUT_CYC cycles have elapsed; 'clear' parks it.
`ifdef RSA_JOB_TIMEOUT_EN
module rsa_job_wdog #(
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_r;
    logic          run_r;
    logic          hit_s;

    assign hit_s   = (cnt_r == CW'(TIMEOUT_CYC));
    assign expired = run_r & hit_s;

    // Cycle counter: restarted on every start, saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            run_r <= 1'b0;
        end else if (clear) begin
            cnt_r <= '0;
            run_r <= 1'b0;
        end else if (start) begin
            cnt_r <= '0;
            run_r <= 1'b1;
        end else if (run_r && !hit_s) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule
`endif

// File: rtl/rsa_job_ctrl.sv
// RSA job controller: runs a batch of jobs by setting the RSA flag,
// polling it until the engine clears it, and counting completions.
// Optional per-job watchdog is enabled by defining RSA_JOB_TIMEOUT_EN.
module rsa_job_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int POLL_GAP    = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    input  logic [15:0]    cmd_count,
    output logic           cmd_ready,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [15:0]    jobs_done,
    rsa_job_ctrl_if.master avm
);
    state_e      state_r;
    logic [15:0] count_r;
    logic [15:0] jobs_done_r;
    logic [15:0] gap_cnt_r;
    logic        abort_r;
    logic        cmd_ready_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic        rd_r;
    logic        wr_r;
    logic        addr_r;
    logic [7:0]  wdata_r;

    logic        bus_ack_s;
    logic        abort_req_s;
    logic        stop_s;
    logic        in_wait_s;
    logic [15:0] next_jobs_s;
    logic        wdog_start_s;
    logic        wdog_clear_s;
    logic        wdog_expired_s;
    logic [6:0]  unused_rdata_s;

    assign cmd_ready         = cmd_ready_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign error             = error_r;
    assign jobs_done         = jobs_done_r;
    assign avm.avm_read      = rd_r;
    assign avm.avm_write     = wr_r;
    assign avm.avm_address   = addr_r;
    assign avm.avm_writedata = wdata_r;
    assign unused_rdata_s    = avm.avm_readdata[7:1];

    // Decode bus acceptance, pending stop requests and watchdog controls.
    always_comb begin
        bus_ack_s    = ~avm.avm_waitrequest;
        abort_req_s  = abort_r | abort;
        next_jobs_s  = jobs_done_r + 16'd1;
        wdog_start_s = 1'b0;
        in_wait_s    = 1'b0;
        wdog_clear_s = ~wdog_active(state_r);
        case (state_r)
            S_SET:         wdog_start_s = bus_ack_s;
            S_GAP, S_POLL: in_wait_s    = 1'b1;
            default:       in_wait_s    = 1'b0;
        endcase
        // A watchdog expiry only counts while waiting on the engine.
        stop_s = abort_req_s | (in_wait_s & wdog_expired_s);
    end

`ifdef RSA_JOB_TIMEOUT_EN
    rsa_job_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .start   (wdog_start_s),
        .clear   (wdog_clear_s),
        .expired (wdog_expired_s)
    );
`else
    logic [33:0] unused_wdog_s;
    assign wdog_expired_s = 1'b0;
    assign unused_wdog_s  = {wdog_start_s, wdog_clear_s, 32'(TIMEOUT_CYC)};
`endif

    // Batch state machine; every output and bus strobe is a register here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            count_r     <= 16'd0;
            jobs_done_r <= 16'd0;
            gap_cnt_r   <= 16'd0;
            abort_r     <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            addr_r      <= 1'b0;
            wdata_r     <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    abort_r <= 1'b0;
                    if (cmd_valid) begin
                        count_r     <= cmd_count;
                        jobs_done_r <= 16'd0;
                        error_r     <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (cmd_count == 16'd0) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_SET;
                            wr_r    <= 1'b1;
                            addr_r  <= FLAG_ADDR;
                            wdata_r <= FLAG_SET;
                        end
                    end
                end
                S_SET: begin
                    abort_r <= abort_req_s;
                    if (bus_ack_s) begin
                        if (abort_req_s) begin
                            // Back-to-back write: the clear follows the accepted set.
                            state_r <= S_CLR;
                            wdata_r <= FLAG_CLR;
                        end else if (POLL_GAP == 0) begin
                            state_r <= S_POLL;
                            wr_r    <= 1'b0;
                            rd_r    <= 1'b1;
                        end else begin
                            state_r   <= S_GAP;
                            wr_r      <= 1'b0;
                            gap_cnt_r <= 16'd0;
                        end
                    end
                end
                S_GAP: begin
                    abort_r <= abort_req_s;
                    if (stop_s) begin
                        state_r <= S_CLR;
                        wr_r    <= 1'b1;
                        addr_r  <= FLAG_ADDR;
                        wdata_r <= FLAG_CLR;
                    end else if (gap_cnt_r == 16'(POLL_GAP - 1)) begin
                        state_r <= S_POLL;
                        rd_r    <= 1'b1;
                        addr_r  <= FLAG_ADDR;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 16'd1;
                    end
                end
                S_POLL: begin
                    abort_r <= abort_req_s;
                    if (bus_ack_s) begin
                        rd_r <= 1'b0;
                        if (!avm.avm_readdata[0]) begin
                            jobs_done_r <= next_jobs_s;
                            if (next_jobs_s == count_r) begin
                                // Final completion beats a coincident stop request.
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
                            end else if (stop_s) begin
                                state_r <= S_CLR;
                                wr_r    <= 1'b1;
                                wdata_r <= FLAG_CLR;
                            end else begin
                                state_r <= S_SET;
                                wr_r    <= 1'b1;
                                wdata_r <= FLAG_SET;
                            end
                        end else if (stop_s) begin
                            state_r <= S_CLR;
                            wr_r    <= 1'b1;
                            wdata_r <= FLAG_CLR;
                        end else if (POLL_GAP == 0) begin
                            rd_r <= 1'b1;
                        end else begin
                            state_r   <= S_GAP;
                            gap_cnt_r <= 16'd0;
                        end
                    end
                end
                S_CLR: begin
                    abort_r <= 1'b0;
                    if (bus_ack_s) begin
                        state_r <= S_DONE;
                        wr_r    <= 1'b0;
                        error_r <= 1'b1;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r     <= S_IDLE;
                    abort_r     <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= S_IDLE;
                    abort_r     <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    rd_r        <= 1'b0;
                    wr_r        <= 1'b0;
                end
            endcase
        end
    end
endmodule
